// File: rtl/if_stage.sv
// Instruction-fetch stage: owns the PC, keeps at most one read outstanding on a
// pipelined instruction bus, and feeds the IF/ID register. Redirects from EX and
// from the trap unit flush the stage; a read that is already in flight when a
// redirect hits is remembered through the drop flag and its response discarded.

package if_stage_pkg;

  typedef struct packed {
    logic valid;
  } if2id_pipeline_ctrl_t;

  typedef struct packed {
    logic [31:0] instruction;
    logic [31:0] pc;
  } if2id_pipeline_data_t;

endpackage

module if_stage
  import if_stage_pkg::*;
#(
  parameter logic [31:0] RESET_VECTOR = 32'h0000_0000
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 if_stall,
  input  logic                 branch_take,
  input  logic [31:0]          branch_target,
  input  logic                 trap_take,
  input  logic [31:0]          trap_pc,
  output logic                 ibus_read,
  output logic [31:0]          ibus_address,
  input  logic                 ibus_waitrequest,
  input  logic                 ibus_readdatavalid,
  input  logic [31:0]          ibus_readdata,
  output if2id_pipeline_ctrl_t if2id_pipeline_ctrl,
  output if2id_pipeline_data_t if2id_pipeline_data
);

  typedef enum logic [0:0] {
    ST_ISSUE = 1'b0,
    ST_WAIT  = 1'b1
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;
  logic [31:0] r_pc;
  logic [31:0] w_pc_nxt;
  logic [31:0] r_fetch_pc;
  logic [31:0] w_fetch_pc_nxt;
  logic        r_drop;
  logic        w_drop_nxt;
  logic        r_hold_valid;
  logic        w_hold_valid_nxt;
  logic [31:0] r_hold_pc;
  logic [31:0] w_hold_pc_nxt;
  logic [31:0] r_hold_instr;
  logic [31:0] w_hold_instr_nxt;
  logic        r_valid;
  logic        w_valid_nxt;
  logic [31:0] r_out_pc;
  logic [31:0] w_out_pc_nxt;
  logic [31:0] r_out_instr;
  logic [31:0] w_out_instr_nxt;

  logic        w_redirect;
  logic [31:0] w_redirect_pc;
  logic        w_read;
  logic        w_accept;
  logic        w_deliver;

  // Trap redirects outrank branch redirects.
  assign w_redirect    = trap_take | branch_take;
  assign w_redirect_pc = trap_take ? trap_pc : branch_target;

  // A new read goes out from ISSUE, or back-to-back from WAIT in the same cycle
  // the current response is delivered straight into IF/ID. Nothing is requested
  // while the hold buffer is occupied, so it never needs more than one entry.
  assign w_read = ~rst & ~w_redirect & ~r_hold_valid &
                  ((r_state == ST_ISSUE) |
                   ((r_state == ST_WAIT) & ibus_readdatavalid & ~r_drop & ~if_stall));
  assign w_accept  = w_read & ~ibus_waitrequest;
  assign w_deliver = (r_state == ST_WAIT) & ibus_readdatavalid & ~r_drop;

  assign ibus_read                       = w_read;
  assign ibus_address                    = r_pc;
  assign if2id_pipeline_ctrl.valid       = r_valid;
  assign if2id_pipeline_data.pc          = r_out_pc;
  assign if2id_pipeline_data.instruction = r_out_instr;

  // Next-state logic: fetch sequencing, redirect flush, hold buffer and IF/ID load.
  always_comb begin
    w_state_nxt      = r_state;
    w_pc_nxt         = r_pc;
    w_fetch_pc_nxt   = r_fetch_pc;
    w_drop_nxt       = r_drop;
    w_hold_valid_nxt = r_hold_valid;
    w_hold_pc_nxt    = r_hold_pc;
    w_hold_instr_nxt = r_hold_instr;
    w_valid_nxt      = r_valid;
    w_out_pc_nxt     = r_out_pc;
    w_out_instr_nxt  = r_out_instr;

    if (w_redirect) begin
      // Flush wins over stall; any response arriving now is thrown away.
      w_pc_nxt         = w_redirect_pc;
      w_valid_nxt      = 1'b0;
      w_hold_valid_nxt = 1'b0;
      case (r_state)
        ST_WAIT: begin
          if (ibus_readdatavalid) begin
            w_state_nxt = ST_ISSUE;
            w_drop_nxt  = 1'b0;
          end else begin
            // Read still in flight: swallow its response when it shows up.
            w_state_nxt = ST_WAIT;
            w_drop_nxt  = 1'b1;
          end
        end
        ST_ISSUE: begin
          w_state_nxt = ST_ISSUE;
          w_drop_nxt  = 1'b0;
        end
        default: begin
          w_state_nxt = ST_ISSUE;
          w_drop_nxt  = 1'b0;
        end
      endcase
    end else begin
      case (r_state)
        ST_ISSUE: begin
          if (w_accept) begin
            w_fetch_pc_nxt = r_pc;
            w_pc_nxt       = r_pc + 32'd4;
            w_state_nxt    = ST_WAIT;
          end else begin
            w_state_nxt = ST_ISSUE;
          end
        end
        ST_WAIT: begin
          if (!ibus_readdatavalid) begin
            w_state_nxt = ST_WAIT;
          end else if (r_drop) begin
            w_drop_nxt  = 1'b0;
            w_state_nxt = ST_ISSUE;
          end else if (w_accept) begin
            w_fetch_pc_nxt = r_pc;
            w_pc_nxt       = r_pc + 32'd4;
            w_state_nxt    = ST_WAIT;
          end else begin
            w_state_nxt = ST_ISSUE;
          end
        end
        default: begin
          w_state_nxt = ST_ISSUE;
          w_drop_nxt  = 1'b0;
        end
      endcase

      if (w_deliver) begin
        if (if_stall) begin
          w_hold_valid_nxt = 1'b1;
          w_hold_pc_nxt    = r_fetch_pc;
          w_hold_instr_nxt = ibus_readdata;
        end else begin
          w_valid_nxt     = 1'b1;
          w_out_pc_nxt    = r_fetch_pc;
          w_out_instr_nxt = ibus_readdata;
        end
      end else if (!if_stall) begin
        if (r_hold_valid) begin
          w_valid_nxt      = 1'b1;
          w_out_pc_nxt     = r_hold_pc;
          w_out_instr_nxt  = r_hold_instr;
          w_hold_valid_nxt = 1'b0;
        end else begin
          w_valid_nxt = 1'b0;
        end
      end else begin
        w_valid_nxt = r_valid;
      end
    end
  end

  // Control state register with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= ST_ISSUE;
      r_pc         <= RESET_VECTOR;
      r_drop       <= 1'b0;
      r_hold_valid <= 1'b0;
      r_valid      <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_pc         <= w_pc_nxt;
      r_drop       <= w_drop_nxt;
      r_hold_valid <= w_hold_valid_nxt;
      r_valid      <= w_valid_nxt;
    end
  end

  // Data-path registers; qualified by their valid bits, so no reset is needed.
  always_ff @(posedge clk) begin
    r_fetch_pc   <= w_fetch_pc_nxt;
    r_hold_pc    <= w_hold_pc_nxt;
    r_hold_instr <= w_hold_instr_nxt;
    r_out_pc     <= w_out_pc_nxt;
    r_out_instr  <= w_out_instr_nxt;
  end

endmodule
